// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receive and transmit sides
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte holding register handshake and error pulses
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with holding register; UART_RX_PARITY_EN adds even parity
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master bus
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam int          IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rxd_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxd_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects glitches shorter than half a bit
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = rxd_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           deliver      = 1'b1;
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A handshake in the delivery cycle frees the register, so the new byte is taken
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 171;
`else
  localparam int EXP_LAT = 155;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int t_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0;
  int         n_rise  = 0;
  int         n_fe    = 0;
  int         n_ov    = 0;
  int         n_pe    = 0;
  int         rise_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid   = n_valid + 1;
      last_data = bus.rx_data;
    end
    if (bus.rx_valid && !prev_valid) begin
      n_rise   = n_rise + 1;
      rise_cyc = cyc;
    end
    prev_valid = bus.rx_valid;
    if (bus.frame_err)  n_fe = n_fe + 1;
    if (bus.overrun)    n_ov = n_ov + 1;
    if (bus.parity_err) n_pe = n_pe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int stop_len);
    t_drop = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par_b, CPB);
`else
    if (par_b) rxd = 1'b1;
`endif
    hold(stop_b, stop_len);
  endtask

  int s_valid, s_rise, s_fe, s_ov, s_pe;

  task automatic snap();
    s_valid = n_valid;
    s_rise  = n_rise;
    s_fe    = n_fe;
    s_ov    = n_ov;
    s_pe    = n_pe;
  endtask

  initial begin
    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid",  32'(bus.rx_valid), 32'd0);
    chk("reset_data",   32'(bus.rx_data), 32'h00);
    chk("reset_fe",     32'(bus.frame_err), 32'd0);
    chk("reset_ov",     32'(bus.overrun), 32'd0);
    chk("reset_pe",     32'(bus.parity_err), 32'd0);
    chk("reset_state",  32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    hold(1'b1, 20);

    // Single byte, consumer always ready
    snap();
    send_frame(8'hA5, 1'b1, ^8'hA5, CPB);
    hold(1'b1, 20);
    chk("a5_rise",      32'(n_rise - s_rise), 32'd1);
    chk("a5_valid_len", 32'(n_valid - s_valid), 32'd1);
    chk("a5_data",      32'(last_data), 32'hA5);
    chk("a5_flags",     32'((n_fe - s_fe) + (n_ov - s_ov) + (n_pe - s_pe)), 32'd0);
    chk("a5_latency_in_window",
        32'((rise_cyc - t_drop >= EXP_LAT - 2) && (rise_cyc - t_drop <= EXP_LAT)), 32'd1);

    // Back-to-back bytes with consumer stalled: second byte overruns
    bus.rx_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, ^8'h3C, CPB);
    send_frame(8'hC3, 1'b1, ^8'hC3, CPB);
    hold(1'b1, 20);
    chk("ovr_valid",    32'(bus.rx_valid), 32'd1);
    chk("ovr_data",     32'(bus.rx_data), 32'h3C);
    chk("ovr_pulses",   32'(n_ov - s_ov), 32'd1);
    chk("ovr_rise",     32'(n_rise - s_rise), 32'd1);
    bus.rx_ready = 1'b1;
    chk("ovr_valid_before_hs", 32'(bus.rx_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("ovr_valid_after_hs", 32'(bus.rx_valid), 32'd0);
    hold(1'b1, 5);

    // Short glitch on the idle line
    snap();
    hold(1'b0, 5);
    hold(1'b1, 40);
    chk("glitch_rise",  32'(n_rise - s_rise), 32'd0);
    chk("glitch_flags", 32'((n_fe - s_fe) + (n_ov - s_ov) + (n_pe - s_pe)), 32'd0);
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));

    // Bad stop bit followed by a held break, then a good byte
    snap();
    send_frame(8'h55, 1'b0, ^8'h55, 40);
    hold(1'b1, 20);
    chk("brk_fe",       32'(n_fe - s_fe), 32'd1);
    chk("brk_rise",     32'(n_rise - s_rise), 32'd0);
    send_frame(8'h0F, 1'b1, ^8'h0F, CPB);
    hold(1'b1, 20);
    chk("brk_next_rise", 32'(n_rise - s_rise), 32'd1);
    chk("brk_next_data", 32'(last_data), 32'h0F);
    chk("brk_fe_total",  32'(n_fe - s_fe), 32'd1);

    // Reset in the middle of bit 4 with a byte held
    bus.rx_ready = 1'b0;
    send_frame(8'h81, 1'b1, ^8'h81, CPB);
    hold(1'b1, 20);
    chk("pre_rst_valid", 32'(bus.rx_valid), 32'd1);
    chk("pre_rst_data",  32'(bus.rx_data), 32'h81);
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b1, CPB / 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid",  32'(bus.rx_valid), 32'd0);
    chk("rst_data",   32'(bus.rx_data), 32'h00);
    chk("rst_fe",     32'(bus.frame_err), 32'd0);
    chk("rst_ov",     32'(bus.overrun), 32'd0);
    chk("rst_pe",     32'(bus.parity_err), 32'd0);
    hold(1'b1, CPB / 2 + 5 * CPB);
    rst = 1'b0;
    hold(1'b1, 20);
    bus.rx_ready = 1'b1;
    snap();
    send_frame(8'hFF, 1'b1, ^8'hFF, CPB);
    hold(1'b1, 20);
    chk("post_rst_rise", 32'(n_rise - s_rise), 32'd1);
    chk("post_rst_data", 32'(last_data), 32'hFF);
    chk("post_rst_fe",   32'(n_fe - s_fe), 32'd0);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h01, 1'b1, 1'b0, CPB);
    hold(1'b1, 20);
    chk("par_bad_pe",    32'(n_pe - s_pe), 32'd1);
    chk("par_bad_rise",  32'(n_rise - s_rise), 32'd0);
    send_frame(8'h01, 1'b1, 1'b1, CPB);
    hold(1'b1, 20);
    chk("par_ok_rise",   32'(n_rise - s_rise), 32'd1);
    chk("par_ok_data",   32'(last_data), 32'h01);
    chk("par_ok_pe",     32'(n_pe - s_pe), 32'd1);
`else
    chk("no_parity_pe", 32'(n_pe), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
